// File: rtl/uart_burst_loader.sv
// uart_burst_loader: boot-time loader that packs serial bytes into 32-bit
// words, pushes them into the MIG write FIFO and issues one write burst
// command per block, raising load_done once the configured block count is in.
// Optional feature macro: UART_LOADER_CHECKSUM_EN adds a 16-bit running sum of
// the payload and a 2-byte trailer check (CHECK state) after the last burst.
module uart_burst_loader #(
    parameter int          LOG2_BURST_WORDS = 6,
    parameter int          LOG2_BURSTS      = 8,
    parameter logic [29:0] BASE_ADDR        = 30'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   calib_done,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   load_done,
    output logic                   load_error,
    output logic [LOG2_BURSTS:0]   progress,
    output logic                   mem_cmd_en,
    output logic [2:0]             mem_cmd_instr,
    output logic [5:0]             mem_cmd_bl,
    output logic [29:0]            mem_cmd_byte_addr,
    input  logic                   mem_cmd_full,
    output logic                   mem_wr_en,
    output logic [3:0]             mem_wr_mask,
    output logic [31:0]            mem_wr_data,
    input  logic                   mem_wr_full
);

    // Byte counter spans one burst; progress counts bursts including the final one.
    localparam int              BCW        = LOG2_BURST_WORDS + 2;
    localparam int              PW         = LOG2_BURSTS + 1;
    localparam logic [PW-1:0]   LAST_LINE  = PW'((32'd1 << LOG2_BURSTS) - 32'd1);
    localparam logic [5:0]      BURST_LEN  = 6'((32'd1 << LOG2_BURST_WORDS) - 32'd1);

    typedef enum logic [2:0] {
        WAIT_CAL = 3'd0,
        RECV     = 3'd1,
        CMD      = 3'd2,
`ifdef UART_LOADER_CHECKSUM_EN
        CHECK    = 3'd3,
`endif
        DONE     = 3'd4,
        ERROR    = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_next;

    logic [BCW-1:0]    byte_cnt_r;
    logic [31:0]       mem_wr_data_r;
    logic              mem_wr_en_r;
    logic              mem_cmd_en_r;
    logic [29:0]       mem_cmd_byte_addr_r;
    logic [PW-1:0]     progress_r;
    logic              skid_valid_r;
    logic [7:0]        skid_data_r;
    logic              load_done_r;
    logic              load_error_r;

    logic [7:0]        byte_s;
    logic              payload_s;
    logic              wr_pulse_s;
    logic              cmd_issue_s;
    logic              skid_load_s;
    logic              skid_valid_next_s;
    logic [29:0]       line_addr_s;

`ifdef UART_LOADER_CHECKSUM_EN
    logic [15:0]       sum_r;
    logic              trailer_cnt_r;
    logic [7:0]        trailer_hi_r;
    logic              trailer_s;
    logic              chk_fail_s;

    // Modulo-2^16 accumulation of one payload byte.
    function automatic logic [15:0] sum_add(input logic [15:0] acc, input logic [7:0] b);
        sum_add = acc + {8'h00, b};
    endfunction
`endif

    // Burst start address for the current line; wraps within 30 bits.
    assign line_addr_s = BASE_ADDR + (30'(progress_r) << BCW);

    assign mem_cmd_instr     = 3'b000;
    assign mem_wr_mask       = 4'b0000;
    assign mem_cmd_bl        = BURST_LEN;
    assign mem_wr_en         = mem_wr_en_r;
    assign mem_wr_data       = mem_wr_data_r;
    assign mem_cmd_en        = mem_cmd_en_r;
    assign mem_cmd_byte_addr = mem_cmd_byte_addr_r;
    assign progress          = progress_r;
    assign load_done         = load_done_r;
    assign load_error        = load_error_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= WAIT_CAL;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state and per-cycle control decode; skid byte has priority over rx.
    always_comb begin
        state_next        = state_r;
        byte_s            = skid_valid_r ? skid_data_r : rx_data;
        payload_s         = 1'b0;
        wr_pulse_s        = 1'b0;
        cmd_issue_s       = 1'b0;
        skid_load_s       = 1'b0;
        skid_valid_next_s = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
        trailer_s         = 1'b0;
        chk_fail_s        = 1'b0;
`endif
        case (state_r)
            WAIT_CAL: begin
                if (calib_done) begin
                    state_next = RECV;
                end else begin
                    state_next = WAIT_CAL;
                end
            end
            RECV: begin
                payload_s         = skid_valid_r | rx_valid;
                // A fresh byte arriving while the skid byte drains refills the skid.
                skid_load_s       = skid_valid_r & rx_valid;
                skid_valid_next_s = skid_valid_r & rx_valid;
                if (payload_s && (byte_cnt_r[1:0] == 2'b11)) begin
                    if (mem_wr_full) begin
                        state_next = ERROR;
                    end else begin
                        wr_pulse_s = 1'b1;
                        if (&byte_cnt_r) begin
                            state_next = CMD;
                        end else begin
                            state_next = RECV;
                        end
                    end
                end else begin
                    state_next = RECV;
                end
            end
            CMD: begin
                if (rx_valid && skid_valid_r) begin
                    state_next        = ERROR;
                    skid_valid_next_s = skid_valid_r;
                end else begin
                    skid_load_s       = rx_valid;
                    skid_valid_next_s = skid_valid_r | rx_valid;
                    if (mem_cmd_full) begin
                        state_next = CMD;
                    end else begin
                        cmd_issue_s = 1'b1;
                        if (progress_r == LAST_LINE) begin
`ifdef UART_LOADER_CHECKSUM_EN
                            state_next = CHECK;
`else
                            state_next = DONE;
`endif
                        end else begin
                            state_next = RECV;
                        end
                    end
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            CHECK: begin
                trailer_s         = skid_valid_r | rx_valid;
                skid_load_s       = skid_valid_r & rx_valid;
                skid_valid_next_s = skid_valid_r & rx_valid;
                if (trailer_s && trailer_cnt_r) begin
                    state_next = DONE;
                    chk_fail_s = ({trailer_hi_r, byte_s} != sum_r);
                end else begin
                    state_next = CHECK;
                end
            end
`endif
            DONE: begin
                state_next = DONE;
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = ERROR;
            end
        endcase
    end

    // Word assembly, FIFO strobes, burst addressing and the skid byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_r          <= '0;
            mem_wr_data_r       <= 32'h0000_0000;
            mem_wr_en_r         <= 1'b0;
            mem_cmd_en_r        <= 1'b0;
            mem_cmd_byte_addr_r <= 30'h0;
            progress_r          <= '0;
            skid_valid_r        <= 1'b0;
            skid_data_r         <= 8'h00;
        end else begin
            if (payload_s) begin
                mem_wr_data_r <= {mem_wr_data_r[23:0], byte_s};
                byte_cnt_r    <= byte_cnt_r + BCW'(1);
            end
            mem_wr_en_r  <= wr_pulse_s;
            mem_cmd_en_r <= cmd_issue_s;
            if (cmd_issue_s) begin
                mem_cmd_byte_addr_r <= line_addr_s;
            end
            // progress follows the command pulse by one cycle.
            if (mem_cmd_en_r) begin
                progress_r <= progress_r + PW'(1);
            end
            skid_valid_r <= skid_valid_next_s;
            if (skid_load_s) begin
                skid_data_r <= rx_data;
            end
        end
    end

    // Sticky completion and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
        end else begin
            load_done_r  <= load_done_r | (state_next == DONE) | (state_next == ERROR);
`ifdef UART_LOADER_CHECKSUM_EN
            load_error_r <= load_error_r | (state_next == ERROR) | chk_fail_s;
`else
            load_error_r <= load_error_r | (state_next == ERROR);
`endif
        end
    end

`ifdef UART_LOADER_CHECKSUM_EN
    // Payload checksum and trailer capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r         <= 16'h0000;
            trailer_cnt_r <= 1'b0;
            trailer_hi_r  <= 8'h00;
        end else begin
            if (payload_s) begin
                sum_r <= sum_add(sum_r, byte_s);
            end
            if (trailer_s) begin
                trailer_cnt_r <= ~trailer_cnt_r;
                if (!trailer_cnt_r) begin
                    trailer_hi_r <= byte_s;
                end
            end
        end
    end
`endif

endmodule

// File: doc/uart_burst_loader.md
# uart_burst_loader

Parametrised boot loader that fills external RAM from a serial byte stream before the CPU starts. Takes bytes from the `uart` receiver, packs them into 32-bit words, and pushes them into the MIG write FIFO. It issues one write burst command per block and raises `load_done` after a configurable number of blocks. Compared with the fixed 64 KiB loader it adds:
- configurable burst size, block count and base address;
- FIFO back-pressure handling;
- a one-byte skid buffer;
- sticky error reporting;
- an optional checksum trailer.

## Interface
- `LOG2_BURST_WORDS`, default 6: log2 of 32-bit words per burst; legal range 0..6. `mem_cmd_bl` = 2^LOG2_BURST_WORDS − 1.
- `LOG2_BURSTS`, default 8: log2 of the number of bursts per load; must be ≥ 1.
- `BASE_ADDR`, default 30'h0: byte address of the first burst.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `calib_done` in 1: MIG calibration complete.
- `rx_valid` in 1: one-cycle strobe, a new byte is on `rx_data`.
- `rx_data` in 8: received byte.
- `load_done` out 1: load finished; sticky.
- `load_error` out 1: overflow or checksum failure; sticky.
- `progress` out LOG2_BURSTS+1: number of burst commands issued so far.
- `mem_cmd_en` out 1, `mem_cmd_instr` out 3, `mem_cmd_bl` out 6, `mem_cmd_byte_addr` out 30, `mem_cmd_full` in 1.
- `mem_wr_en` out 1, `mem_wr_mask` out 4, `mem_wr_data` out 32, `mem_wr_full` in 1.

## Operation
- Constant outputs: `mem_cmd_instr` = 3'b000 (write), `mem_wr_mask` = 4'b0000.
- States: WAIT_CAL, RECV, CMD, optional CHECK, DONE, ERROR.
- WAIT_CAL: `rx_valid` is ignored and bytes are dropped. Moves to RECV the cycle after `calib_done` is sampled high.
- RECV, each accepted byte:
  - `mem_wr_data` <= {`mem_wr_data`[23:0], `rx_data`}, so the first byte of a word is its MSB.
  - The byte counter increments.
- RECV, word completion:
  - On the 4th byte of a word: if `mem_wr_full` = 0, pulse `mem_wr_en` next cycle; otherwise go to ERROR.
  - On the last byte of a burst: go to CMD.
- CMD:
  - While `mem_cmd_full` = 1, wait.
  - Otherwise pulse `mem_cmd_en` for exactly one cycle with `mem_cmd_byte_addr` = BASE_ADDR + (line << (LOG2_BURST_WORDS+2)), truncated to 30 bits (wraps).
  - Then `progress` increments and line increments.
  - Next state: RECV if more bursts remain; otherwise CHECK (if compiled in) or DONE.
- Skid buffer:
  - A byte arriving in CMD is held in the one-byte skid register and consumed on the first cycle back in RECV.
  - A second byte arriving while the skid register is occupied goes to ERROR.
- DONE: `load_done` = 1. Further bytes are ignored.
- ERROR: `load_error` = 1 and `load_done` = 1. No further `mem_wr_en` or `mem_cmd_en`. Exit only by reset.
- Reset (any time, including mid-burst):
  - All registers clear and the state returns to WAIT_CAL.
  - Partially assembled words and bursts are discarded; nothing is flushed to the FIFOs.

## Timing
- Reset values: `load_done` 0, `load_error` 0, `progress` 0, `mem_cmd_en` 0, `mem_wr_en` 0, `mem_wr_data` 0, `mem_cmd_byte_addr` 0.
- Byte on cycle T completes a word → `mem_wr_en` high on T+1 with the full word on `mem_wr_data`.
- Last byte of a burst on T → `mem_wr_en` on T+1, earliest `mem_cmd_en` on T+2. Data therefore always precedes its command.
- `mem_cmd_byte_addr` is stable on the `mem_cmd_en` cycle; `progress` updates on the following cycle.
- `mem_wr_full` is sampled on the cycle the 4th byte is accepted.
- `mem_cmd_full` is sampled every CMD cycle.
- `rx_valid` in the same cycle as the CMD→RECV transition goes to the skid register. This does not count as a second byte.

## Configuration
- `UART_LOADER_CHECKSUM_EN` defined:
  - A 16-bit running sum (mod 2^16) of all payload bytes is kept.
  - After the last burst command the block enters CHECK and accepts 2 trailer bytes, MSB first.
  - Match → DONE. Mismatch → DONE with `load_error` = 1.
  - `mem_wr_en` and `mem_cmd_en` stay low in CHECK.
- Undefined: no sum logic and no CHECK state. `load_error` reports overflow only.

## Test plan
Bench parameters: LOG2_BURST_WORDS = 1, LOG2_BURSTS = 2, BASE_ADDR = 30'h100.
- `calib_done` = 0 with 5 bytes sent, then `calib_done` = 1 → zero `mem_wr_en` pulses for those bytes; `progress` stays 0.
- 32 bytes 0x00..0x1F, FIFOs never full →
  - 8 `mem_wr_en` pulses, first data 0x00010203, last 0x1C1D1E1F;
  - 4 `mem_cmd_en` at 0x100, 0x108, 0x110, 0x118, `mem_cmd_bl` = 1;
  - `progress` = 4, `load_done` = 1.
- `mem_cmd_full` held 6 cycles after the burst-0 end, one byte sent during the wait → `mem_cmd_en` on the first non-full cycle; that byte appears as MSB of word 2; no error.
- `mem_wr_full` = 1 when the 4th byte arrives → no `mem_wr_en`, `load_error` = `load_done` = 1, later bytes produce no writes.
- `rst_n` pulsed low after 13 bytes, then a full 32-byte load → first command address 0x100, no stale word data.
- With `UART_LOADER_CHECKSUM_EN`, a 32-byte load of 0x00..0x1F:
  - trailer 0x01F0 → `load_error` = 0;
  - trailer 0x01F1 → `load_error` = 1.
